// File: rtl/cs_fifoc2cs.sv
// cs_fifoc2cs: pops one command frame from fifoc, checks header and checksum,
// and commits the nine payload bytes to cmd_* atomically for cs_cmd.
module cs_fifoc2cs #(
    parameter logic [7:0] HEAD0   = 8'h55,
    parameter logic [7:0] HEAD1   = 8'hAA,
    parameter int         TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_dev,
    input  logic       fs,
    output logic       fd,
    input  logic       fifoc_empty,
    output logic       fifoc_rxen,
    input  logic [7:0] fifoc_rxd,
    output logic       err,
    output logic [7:0] cmd_kdev,
    output logic [7:0] cmd_smpr,
    output logic [7:0] cmd_filt,
    output logic [7:0] cmd_mix0,
    output logic [7:0] cmd_mix1,
    output logic [7:0] cmd_reg4,
    output logic [7:0] cmd_reg5,
    output logic [7:0] cmd_reg6,
    output logic [7:0] cmd_reg7
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, HUNT0, HUNT1, DATA, CSUM, DONE} state_t;
    state_t          state;
    logic            rd_out;
    logic [3:0]      idx;
    logic [7:0]      sum;
    logic [TW-1:0]   tcnt;
    logic [8:0][7:0] shadow;
    logic [8:0][7:0] cmd;
    logic            reading;
    logic            counting;
    logic            tmo;
    assign reading    = state inside {HUNT0, HUNT1, DATA, CSUM};
    assign counting   = state inside {HUNT1, DATA, CSUM};
    // gating on fs keeps an aborting handshake from popping a byte it would only drop
    assign fifoc_rxen = reading && fs && !fifoc_empty && !rd_out;
    assign tmo        = counting && !rd_out && tcnt == TW'(TIMEOUT);
    assign {cmd_reg7, cmd_reg6, cmd_reg5, cmd_reg4, cmd_mix1,
            cmd_mix0, cmd_filt, cmd_smpr, cmd_kdev} = cmd;
    always_ff @(posedge clk or posedge rst_dev) begin
        if (rst_dev) begin
            state  <= IDLE;
            rd_out <= 1'b0;
            idx    <= '0;
            sum    <= '0;
            tcnt   <= '0;
            shadow <= '0;
            cmd    <= '0;
            fd     <= 1'b0;
            err    <= 1'b0;
        end else begin
            rd_out <= fifoc_rxen;
            tcnt   <= (!counting || rd_out) ? '0 : (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + 1'b1;
            if (reading && !fs) begin
                state  <= IDLE;
                rd_out <= 1'b0;
            end else if (rd_out) begin
                case (state)
                    HUNT0: if (fifoc_rxd == HEAD0) state <= HUNT1;
                    HUNT1: begin
                        if (fifoc_rxd == HEAD1) begin
                            state <= DATA;
                            idx   <= '0;
                            sum   <= '0;
                        end else if (fifoc_rxd != HEAD0) state <= HUNT0;
                    end
                    DATA: begin
                        shadow[idx] <= fifoc_rxd;
                        sum         <= sum + fifoc_rxd;
                        idx         <= idx + 4'd1;
                        if (idx == 4'd8) state <= CSUM;
                    end
                    CSUM: begin
                        if (fifoc_rxd == sum) begin
                            cmd   <= shadow;
                            fd    <= 1'b1;
                            state <= DONE;
                        end else begin
                            err   <= 1'b1;
                            state <= HUNT0;
                        end
                    end
                    default: ;
                endcase
            end else if (tmo) begin
                err   <= 1'b1;
                state <= HUNT0;
            end else if (state == IDLE && fs) begin
                state <= HUNT0;
            end else if (state == DONE && !fs) begin
                state <= IDLE;
                fd    <= 1'b0;
            end
        end
    end
endmodule
